// File: rtl/button_click_decoder.sv
// ============================================================================
// Module   : button_click_decoder
// Brief    : Classifies a debounced button level into single / double / long
//            click pulses with a wrapping event count. Optional auto-repeat
//            while long-held is enabled by defining BTN_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_click_decoder #(
    parameter int CNT_W      = 26,
    parameter int LONG_CYC   = 50_000_000,
    parameter int GAP_CYC    = 30_000_000,
    parameter int REPEAT_CYC = 10_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_level,
    output logic       click_single,
    output logic       click_double,
    output logic       click_long,
    output logic       click_repeat,
    output logic [7:0] evt_cnt,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_GAP    = 3'd2,
        S_PRESS2 = 3'd3,
        S_LONG   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_long_last   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] c_gap_last    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] c_repeat_last = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] c_timer_one   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_next;
    logic             r_btn_q;
    logic             w_rise;
    logic             w_fall;
    logic             r_single;
    logic             r_double;
    logic             r_long;
    logic             w_single_next;
    logic             w_double_next;
    logic             w_long_next;
    logic             w_evt_next;
    logic [7:0]       r_evt_cnt;

`ifdef BTN_AUTOREPEAT_EN
    logic             r_repeat;
    logic             w_repeat_next;
`else
    logic             w_unused_cfg;
`endif

    // btn_q resets high so a button held through reset never looks like a press
    assign w_rise = btn_level & ~r_btn_q;
    assign w_fall = ~btn_level & r_btn_q;

    always_comb begin
        w_state_next  = r_state;
        w_timer_next  = r_timer;
        w_single_next = 1'b0;
        w_double_next = 1'b0;
        w_long_next   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        w_repeat_next = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_next = S_PRESS1;
                end
            end
            S_PRESS1: begin
                if (w_fall) begin
                    w_state_next = S_GAP;
                end else if (r_timer == c_long_last) begin
                    w_state_next = S_LONG;
                    w_long_next  = 1'b1;
                end
            end
            S_GAP: begin
                if (w_rise) begin
                    w_state_next = S_PRESS2;
                end else if (r_timer == c_gap_last) begin
                    w_state_next  = S_IDLE;
                    w_single_next = 1'b1;
                end
            end
            S_PRESS2: begin
                if (w_fall) begin
                    w_state_next  = S_IDLE;
                    w_double_next = 1'b1;
                end
            end
            S_LONG: begin
                if (w_fall) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Any state change restarts the timer; otherwise it runs in timed states
        if (w_state_next != r_state) begin
            w_timer_next = '0;
        end else if ((r_state == S_PRESS1) || (r_state == S_GAP)) begin
            w_timer_next = r_timer + c_timer_one;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (r_state == S_LONG) begin
            if (r_timer == c_repeat_last) begin
                w_timer_next  = '0;
                w_repeat_next = 1'b1;
            end else begin
                w_timer_next = r_timer + c_timer_one;
            end
        end
`endif
    end

    assign w_evt_next = w_single_next | w_double_next | w_long_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_btn_q   <= 1'b1;
            r_single  <= 1'b0;
            r_double  <= 1'b0;
            r_long    <= 1'b0;
            r_evt_cnt <= 8'd0;
        end else begin
            r_state  <= w_state_next;
            r_timer  <= w_timer_next;
            r_btn_q  <= btn_level;
            r_single <= w_single_next;
            r_double <= w_double_next;
            r_long   <= w_long_next;
            if (w_evt_next) begin
                r_evt_cnt <= r_evt_cnt + 8'd1;
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_repeat <= 1'b0;
        end else begin
            r_repeat <= w_repeat_next;
        end
    end

    assign click_repeat = r_repeat;
`else
    assign w_unused_cfg = ^c_repeat_last;
    assign click_repeat = 1'b0;
`endif

    assign click_single = r_single;
    assign click_double = r_double;
    assign click_long   = r_long;
    assign evt_cnt      = r_evt_cnt;
    assign busy         = (r_state != S_IDLE);

endmodule

`default_nettype wire
